// File: rtl/ddr_stream_arbiter_pkg.sv
// Shared types and constants for the DDR ring-buffer stream arbiter.
package lpc_ddr_pkg;

  localparam int unsigned BurstCntW    = 7;
  localparam int unsigned DefaultBurst = 16;

  typedef enum logic [1:0] {StIdle, StWrBurst, StRdCmd, StRdWait} state_e;
  typedef enum logic {GrantRead, GrantWrite} grant_e;

endpackage

// File: rtl/ddr_stream_arbiter_if.sv
// Stream-FIFO and Avalon-MM signals seen by the arbiter; master = arbiter side.
interface ddr_stream_arbiter_if #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 25,
  parameter int unsigned LEVEL_W = 10
);
  import lpc_ddr_pkg::*;

  logic [LEVEL_W-1:0]   wr_fifo_level;
  logic [DATA_W-1:0]    wr_fifo_data;
  logic                 wr_fifo_rd;
  logic [LEVEL_W-1:0]   rd_fifo_space;
  logic                 rd_fifo_wr;
  logic [DATA_W-1:0]    rd_fifo_data;
  logic [ADDR_W-1:0]    avm_address;
  logic [BurstCntW-1:0] avm_burstcount;
  logic                 avm_write;
  logic [DATA_W-1:0]    avm_writedata;
  logic                 avm_read;
  logic                 avm_waitrequest;
  logic [DATA_W-1:0]    avm_readdata;
  logic                 avm_readdatavalid;

  modport master (
    input  wr_fifo_level, wr_fifo_data, rd_fifo_space,
           avm_waitrequest, avm_readdata, avm_readdatavalid,
    output wr_fifo_rd, rd_fifo_wr, rd_fifo_data,
           avm_address, avm_burstcount, avm_write, avm_writedata, avm_read
  );

  modport slave (
    output wr_fifo_level, wr_fifo_data, rd_fifo_space,
           avm_waitrequest, avm_readdata, avm_readdatavalid,
    input  wr_fifo_rd, rd_fifo_wr, rd_fifo_data,
           avm_address, avm_burstcount, avm_write, avm_writedata, avm_read
  );
endinterface

// File: rtl/ddr_stream_arbiter_ring_tracker.sv
// Ring-buffer bookkeeping: write/read pointers and fill count, advanced one burst at a time.
module ddr_ring_tracker #(
  parameter int unsigned RING_LOG2 = 20,
  parameter int unsigned BURST     = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wr_done,
  input  logic                 i_rd_done,
  output logic [RING_LOG2-1:0] o_wr_ptr,
  output logic [RING_LOG2-1:0] o_rd_ptr,
  output logic [RING_LOG2:0]   o_fill,
  output logic                 o_can_write,
  output logic                 o_can_read
);

  localparam logic [RING_LOG2-1:0] BurstPtr  = RING_LOG2'(BURST);
  localparam logic [RING_LOG2:0]   BurstFill = (RING_LOG2 + 1)'(BURST);
  localparam logic [RING_LOG2:0]   FillMax   = (RING_LOG2 + 1)'((2 ** RING_LOG2) - BURST);

  logic [RING_LOG2-1:0] r_wr_ptr;
  logic [RING_LOG2-1:0] r_rd_ptr;
  logic [RING_LOG2:0]   r_fill;

  // Pointers wrap naturally at the ring size; done strobes are mutually exclusive.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
    end else begin
      if (i_wr_done) begin
        r_wr_ptr <= r_wr_ptr + BurstPtr;
        r_fill   <= r_fill + BurstFill;
      end else if (i_rd_done) begin
        r_rd_ptr <= r_rd_ptr + BurstPtr;
        r_fill   <= r_fill - BurstFill;
      end
    end
  end

  assign o_wr_ptr    = r_wr_ptr;
  assign o_rd_ptr    = r_rd_ptr;
  assign o_fill      = r_fill;
  assign o_can_write = (r_fill <= FillMax);
  assign o_can_read  = (r_fill >= BurstFill);

endmodule

// File: rtl/ddr_stream_arbiter.sv
// Shares one Avalon-MM DDR port between a write stream and a read stream over a ring buffer.
module ddr_stream_arbiter
  import lpc_ddr_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 25,
  parameter int unsigned RING_LOG2  = 20,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned BURST      = DefaultBurst,
  parameter int unsigned LEVEL_W    = 10,
  parameter int unsigned HIGH_WATER = 512
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  input  logic                  init_done,
  ddr_stream_arbiter_if.master  bus,
  output logic [RING_LOG2:0]    ring_fill,
  output logic                  ring_overrun
);

  localparam int unsigned        BeatW    = $clog2(BURST) + 1;
  localparam logic [BeatW-1:0]   BeatLast = BeatW'(BURST - 1);
  localparam logic [ADDR_W-1:0]  Base     = ADDR_W'(BASE_ADDR);

  state_e             r_state, w_state_d;
  grant_e             r_last, w_last_d;
  logic [BeatW-1:0]   r_beat, w_beat_d;
  logic               r_overrun, w_overrun_d;
  logic               w_wr_done, w_rd_done;
  logic [RING_LOG2-1:0] w_wr_ptr, w_rd_ptr;
  logic               w_can_write, w_can_read;
  logic               w_level_ok, w_space_ok, w_high;
  logic               w_elig_wr, w_elig_rd, w_wr_accept, w_rd_beat;

  ddr_ring_tracker #(
    .RING_LOG2 (RING_LOG2),
    .BURST     (BURST)
  ) u_tracker (
    .i_clk       (clk_clk),
    .i_rst       (reset_reset),
    .i_wr_done   (w_wr_done),
    .i_rd_done   (w_rd_done),
    .o_wr_ptr    (w_wr_ptr),
    .o_rd_ptr    (w_rd_ptr),
    .o_fill      (ring_fill),
    .o_can_write (w_can_write),
    .o_can_read  (w_can_read)
  );

  assign w_level_ok  = (32'(bus.wr_fifo_level) >= BURST);
  assign w_space_ok  = (32'(bus.rd_fifo_space) >= BURST);
  assign w_high      = (32'(bus.wr_fifo_level) >= HIGH_WATER);
  assign w_elig_wr   = w_level_ok & w_can_write;
  assign w_elig_rd   = w_space_ok & w_can_read;
  assign w_wr_accept = (r_state == StWrBurst) & ~bus.avm_waitrequest;
  assign w_rd_beat   = (r_state == StRdWait) & bus.avm_readdatavalid;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_state   <= StIdle;
      r_last    <= GrantRead;
      r_beat    <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_last    <= w_last_d;
      r_beat    <= w_beat_d;
      r_overrun <= w_overrun_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_last_d    = r_last;
    w_beat_d    = r_beat;
    w_overrun_d = r_overrun;
    w_wr_done   = 1'b0;
    w_rd_done   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_level_ok && !w_can_write) w_overrun_d = 1'b1;
        // High water overrides round-robin so the write FIFO cannot overflow.
        if (init_done) begin
          if (w_elig_wr && (!w_elig_rd || w_high || r_last == GrantRead)) begin
            w_state_d = StWrBurst;
            w_last_d  = GrantWrite;
          end else if (w_elig_rd) begin
            w_state_d = StRdCmd;
            w_last_d  = GrantRead;
          end
        end
      end
      StWrBurst: begin
        if (w_wr_accept) begin
          if (r_beat == BeatLast) begin
            w_wr_done = 1'b1;
            w_beat_d  = '0;
            w_state_d = StIdle;
          end else begin
            w_beat_d = r_beat + BeatW'(1);
          end
        end
      end
      StRdCmd: begin
        if (!bus.avm_waitrequest) w_state_d = StRdWait;
      end
      StRdWait: begin
        if (w_rd_beat) begin
          if (r_beat == BeatLast) begin
            w_rd_done = 1'b1;
            w_beat_d  = '0;
            w_state_d = StIdle;
          end else begin
            w_beat_d = r_beat + BeatW'(1);
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign bus.avm_write      = (r_state == StWrBurst);
  assign bus.avm_read       = (r_state == StRdCmd);
  assign bus.avm_burstcount = (bus.avm_write | bus.avm_read) ? BurstCntW'(BURST) : '0;
  assign bus.avm_address    = (r_state == StWrBurst) ? Base + ADDR_W'(w_wr_ptr) :
                              (r_state == StRdCmd)   ? Base + ADDR_W'(w_rd_ptr) : '0;
  assign bus.avm_writedata  = (r_state == StWrBurst) ? bus.wr_fifo_data : '0;
  assign bus.wr_fifo_rd     = w_wr_accept;
  assign bus.rd_fifo_wr     = w_rd_beat;
  assign bus.rd_fifo_data   = (r_state == StRdWait) ? bus.avm_readdata : '0;
  assign ring_overrun       = r_overrun;

endmodule

// File: tb/tb_ddr_stream_arbiter.sv
// Directed bench for ddr_stream_arbiter on a 64-word ring with 16-word bursts.
module tb_ddr_stream_arbiter;

  logic        clk;
  logic        rst;
  logic        init_done;
  logic [6:0]  ring_fill;
  logic        ring_overrun;
  logic [15:0] head;
  int          n_checks;
  int          n_errors;

  ddr_stream_arbiter_if #(.DATA_W(16), .ADDR_W(25), .LEVEL_W(10)) bus ();

  ddr_stream_arbiter #(
    .DATA_W     (16),
    .ADDR_W     (25),
    .RING_LOG2  (6),
    .BASE_ADDR  (0),
    .BURST      (16),
    .LEVEL_W    (10),
    .HIGH_WATER (512)
  ) dut (
    .clk_clk      (clk),
    .reset_reset  (rst),
    .init_done    (init_done),
    .bus          (bus),
    .ring_fill    (ring_fill),
    .ring_overrun (ring_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for a write burst, models the show-ahead FIFO head and stalls cycles lo..hi.
  task automatic do_write(input int lo, input int hi, input logic [31:0] addr);
    int   cyc    = 0;
    int   pulses = 0;
    bit   started = 0;
    bit   pop    = 0;
    logic wq;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (pop) head = head + 16'd1;
      bus.wr_fifo_data = head;
      pop = 0;
      if (!bus.avm_write) begin
        if (started) break;
        continue;
      end
      started = 1;
      wq = (cyc >= lo && cyc <= hi);
      bus.avm_waitrequest = wq;
      #1;
      chk("wr_addr", 32'(bus.avm_address), addr);
      chk("wr_burstcount", 32'(bus.avm_burstcount), 32'd16);
      chk("wr_data", 32'(bus.avm_writedata), 32'(head));
      chk("wr_fifo_rd", 32'(bus.wr_fifo_rd), 32'(!wq));
      pop = bus.wr_fifo_rd;
      pulses += int'(pop);
      cyc++;
    end
    bus.avm_waitrequest = 1'b0;
    chk("wr_started", 32'(started), 32'd1);
    chk("wr_pulses", pulses, 32'd16);
  endtask

  // Waits for a read command (one stall cycle), injects a stray beat, then 16 beats with a gap.
  task automatic do_read(input logic [31:0] addr);
    int pulses = 0;
    int sent   = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.avm_read) break;
    end
    chk("rd_cmd", 32'(bus.avm_read), 32'd1);
    chk("rd_addr", 32'(bus.avm_address), addr);
    chk("rd_burstcount", 32'(bus.avm_burstcount), 32'd16);
    bus.avm_waitrequest = 1'b1;
    @(negedge clk);
    chk("rd_cmd_held", 32'(bus.avm_read), 32'd1);
    chk("rd_addr_held", 32'(bus.avm_address), addr);
    bus.avm_waitrequest   = 1'b0;
    bus.avm_readdatavalid = 1'b1;
    bus.avm_readdata      = 16'hDEAD;
    #1;
    chk("rd_stray_ignored", 32'(bus.rd_fifo_wr), 32'd0);
    @(negedge clk);
    chk("rd_cmd_dropped", 32'(bus.avm_read), 32'd0);
    for (int i = 0; i < 17; i++) begin
      bus.avm_readdatavalid = (i != 5);
      bus.avm_readdata      = 16'hA000 + 16'(sent);
      #1;
      chk("rd_fifo_wr", 32'(bus.rd_fifo_wr), 32'(i != 5));
      if (i != 5) begin
        chk("rd_fifo_data", 32'(bus.rd_fifo_data), 32'(16'hA000 + 16'(sent)));
        sent++;
      end
      pulses += int'(bus.rd_fifo_wr);
      @(negedge clk);
    end
    bus.avm_readdatavalid = 1'b0;
    chk("rd_pulses", pulses, 32'd16);
    chk("rd_idle_after", 32'(bus.avm_read), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    head     = 16'h1000;
    rst      = 1'b1;
    init_done = 1'b0;
    bus.wr_fifo_level     = '0;
    bus.wr_fifo_data      = head;
    bus.rd_fifo_space     = '0;
    bus.avm_waitrequest   = 1'b0;
    bus.avm_readdata      = '0;
    bus.avm_readdatavalid = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_write", 32'(bus.avm_write), 32'd0);
    chk("rst_read", 32'(bus.avm_read), 32'd0);
    chk("rst_fill", 32'(ring_fill), 32'd0);
    chk("rst_overrun", 32'(ring_overrun), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: nothing issued before calibration, then a write at address 0
    bus.wr_fifo_level = 10'd100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("noinit_write", 32'(bus.avm_write), 32'd0);
      chk("noinit_read", 32'(bus.avm_read), 32'd0);
    end
    init_done = 1'b1;

    // 2: stalled write burst, then back-to-back unstalled write
    do_write(2, 4, 32'd0);
    chk("fill_after_w0", 32'(ring_fill), 32'd16);
    do_write(99, 99, 32'd16);
    chk("fill_after_w1", 32'(ring_fill), 32'd32);

    // 3: read only eligible
    bus.wr_fifo_level = 10'd0;
    bus.rd_fifo_space = 10'd64;
    do_read(32'd0);
    chk("fill_after_r0", 32'(ring_fill), 32'd16);

    // 4: round-robin W,R,W,R
    bus.wr_fifo_level = 10'd100;
    do_write(99, 99, 32'd32);
    chk("fill_rr_w", 32'(ring_fill), 32'd32);
    do_read(32'd16);
    do_write(99, 99, 32'd48);
    do_read(32'd32);
    chk("fill_rr_end", 32'(ring_fill), 32'd16);

    // 4/5: high water forces consecutive writes; write pointer wraps 48 -> 0
    bus.wr_fifo_level = 10'd600;
    do_write(99, 99, 32'd0);
    do_write(99, 99, 32'd16);
    bus.rd_fifo_space = 10'd0;
    do_write(99, 99, 32'd32);
    chk("fill_full", 32'(ring_fill), 32'd64);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("full_no_write", 32'(bus.avm_write), 32'd0);
      chk("full_no_read", 32'(bus.avm_read), 32'd0);
    end
    chk("overrun_set", 32'(ring_overrun), 32'd1);

    // 5: read pointer wraps 48 -> 0
    bus.wr_fifo_level = 10'd0;
    bus.rd_fifo_space = 10'd64;
    do_read(32'd48);
    do_read(32'd0);
    bus.rd_fifo_space = 10'd0;
    chk("fill_after_wrap", 32'(ring_fill), 32'd32);
    chk("overrun_sticky", 32'(ring_overrun), 32'd1);

    // 6: reset mid-write clears everything immediately
    bus.wr_fifo_level = 10'd100;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.avm_write) break;
    end
    chk("w_before_rst", 32'(bus.avm_write), 32'd1);
    chk("w_addr_before_rst", 32'(bus.avm_address), 32'd48);
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_write", 32'(bus.avm_write), 32'd0);
    chk("midrst_read", 32'(bus.avm_read), 32'd0);
    chk("midrst_fifo_rd", 32'(bus.wr_fifo_rd), 32'd0);
    chk("midrst_addr", 32'(bus.avm_address), 32'd0);
    chk("midrst_burstcount", 32'(bus.avm_burstcount), 32'd0);
    chk("midrst_wdata", 32'(bus.avm_writedata), 32'd0);
    chk("midrst_fill", 32'(ring_fill), 32'd0);
    chk("midrst_overrun", 32'(ring_overrun), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_write(99, 99, 32'd0);
    chk("fill_after_rst", 32'(ring_fill), 32'd16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
